// File: rtl/sram64_bus_bridge_pkg.sv
// Shared types for the SRAM-to-bus bridge: FSM states, captured request payload, alignment helper.
package sram64_bus_pkg;

  localparam int BUS_ALIGN  = 3;
  localparam int BUS_ADDR_W = 64;
  localparam int BUS_DATA_W = 64;
  localparam int BUS_STRB_W = BUS_DATA_W / 8;
  localparam int WDT_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic                  write;
    logic [BUS_STRB_W-1:0] wstrb;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

  // Lane selection lives in the byte strobes, so the bus only ever sees whole 8-byte words.
  function automatic logic [BUS_ADDR_W-1:0] align_addr(input logic [BUS_ADDR_W-1:0] a);
    return {a[BUS_ADDR_W-1:BUS_ALIGN], {BUS_ALIGN{1'b0}}};
  endfunction

endpackage

// File: rtl/sram64_bus_bridge_if.sv
// Valid/ready request + response bus between the bridge (master) and external memory (slave).
interface sram64_bus_bridge_if #(
  parameter int ADDR_W = 64
);

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_req_addr;
  logic              bus_req_write;
  logic [7:0]        bus_req_wstrb;
  logic [63:0]       bus_req_wdata;
  logic              bus_resp_valid;
  logic              bus_resp_ready;
  logic [63:0]       bus_resp_data;
  logic              bus_resp_err;

  modport master (
    output bus_req_valid,
    input  bus_req_ready,
    output bus_req_addr,
    output bus_req_write,
    output bus_req_wstrb,
    output bus_req_wdata,
    input  bus_resp_valid,
    output bus_resp_ready,
    input  bus_resp_data,
    input  bus_resp_err
  );

  modport slave (
    input  bus_req_valid,
    output bus_req_ready,
    input  bus_req_addr,
    input  bus_req_write,
    input  bus_req_wstrb,
    input  bus_req_wdata,
    output bus_resp_valid,
    input  bus_resp_ready,
    output bus_resp_data,
    output bus_resp_err
  );

endinterface

// File: rtl/sram64_bus_bridge_wdt.sv
// Bridge watchdog: counts enabled cycles since clear; expired_o is combinational once TIMEOUT_CYCLES
// enabled cycles have elapsed. clear_i wins over enable_i. Used only with SRAM64_BUS_BRIDGE_TIMEOUT_EN.
module sram64_bridge_wdt
  import sram64_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [WDT_CNT_W-1:0] cnt_q;
  logic [WDT_CNT_W-1:0] cnt_d;

  assign expired_o = enable_i && (cnt_q == WDT_CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + WDT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram64_bus_bridge.sv
// Converts each SRAM-style MEM-stage access into one bus transaction; >=4 cycles (IDLE,REQ,RESP,DONE),
// stall held until DONE, each ready/resp wait adds a cycle. SRAM64_BUS_BRIDGE_TIMEOUT_EN adds a watchdog.
module sram64_bus_bridge
  import sram64_bus_pkg::*;
#(
  parameter int          ADDR_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sram_en,
  input  logic [ADDR_W-1:0]   sram_addr,
  input  logic [7:0]          sram_wea,
  input  logic [63:0]         sram_dina,
  output logic [63:0]         sram_douta,
  output logic                stall,
  output logic                access_fault,
  sram64_bus_bridge_if.master bus
);

  bridge_state_e state_q;
  bridge_state_e state_d;
  bus_req_t      req_q;
  bus_req_t      req_d;
  logic [63:0]   douta_q;
  logic [63:0]   douta_d;
  logic          err_q;
  logic          err_d;
  logic          wdt_expired;

`ifdef SRAM64_BUS_BRIDGE_TIMEOUT_EN
  logic wdt_clear;
  logic wdt_en;

  // Restarting on the IDLE->REQ transition gives every transaction the full budget.
  assign wdt_clear = (state_q == IDLE) && sram_en;
  assign wdt_en    = (state_q == REQ) || (state_q == RESP);

  sram64_bridge_wdt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (wdt_clear),
    .enable_i  (wdt_en),
    .expired_o (wdt_expired)
  );
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign wdt_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    douta_d = douta_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (sram_en) begin
          req_d.addr  = align_addr(BUS_ADDR_W'(sram_addr));
          req_d.write = |sram_wea;
          req_d.wstrb = sram_wea;
          req_d.wdata = sram_dina;
          err_d       = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.bus_req_ready) begin
          state_d = RESP;
        end else if (wdt_expired) begin
          if (!req_q.write) douta_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      RESP: begin
        // A real response in the expiry cycle still wins over the timeout.
        if (bus.bus_resp_valid) begin
          if (!req_q.write) douta_d = bus.bus_resp_data;
          err_d   = bus.bus_resp_err;
          state_d = DONE;
        end else if (wdt_expired) begin
          if (!req_q.write) douta_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      douta_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      douta_q <= douta_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_req_valid  = (state_q == REQ);
  assign bus.bus_req_addr   = req_q.addr[ADDR_W-1:0];
  assign bus.bus_req_write  = req_q.write;
  assign bus.bus_req_wstrb  = req_q.wstrb;
  assign bus.bus_req_wdata  = req_q.wdata;
  assign bus.bus_resp_ready = (state_q == RESP);

  // Stall rises in the same cycle as sram_en; gated by rst_n so it stays low through reset.
  assign stall        = rst_n && ((state_q == IDLE) ? sram_en : (state_q != DONE));
  assign access_fault = (state_q == DONE) && err_q;
  assign sram_douta   = douta_q;

endmodule

// File: doc/sram64_bus_bridge.md
Name: sram64_bus_bridge

Overview:
- Sits directly downstream of the load/store byte-lane translator in the MEM stage.
- Takes its SRAM-style port (enable, 8-bit byte write-enable, 64-bit address, data in, data out) and converts each access into one transaction on a valid/ready request/response bus to external memory.
- Stalls the pipeline until the transaction completes.
- Returns read data on the SRAM-style `douta` port so the translator's extract/sign-extend logic is unchanged.

Parameters:
- ADDR_W, 64, width of pipeline and bus address.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sram_en  in  1  access request from MEM stage, held high while stall is high
- sram_addr  in  ADDR_W  byte address
- sram_wea  in  8  byte write-enable; nonzero = write, zero = read
- sram_dina  in  64  lane-positioned write data
- sram_douta  out  64  read data, lane-positioned
- stall  out  1  pipeline hold request
- access_fault  out  1  one-cycle pulse on bus error (or timeout)
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_addr  out  ADDR_W  8-byte-aligned address
- bus_req_write  out  1  1 = write
- bus_req_wstrb  out  8  byte strobes
- bus_req_wdata  out  64  write data
- bus_resp_valid  in  1  response valid
- bus_resp_ready  out  1  response accepted
- bus_resp_data  in  64  read data
- bus_resp_err  in  1  error flag qualifying bus_resp_valid

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0: sram_douta, stall, access_fault, bus_req_valid, bus_req_addr/write/wstrb/wdata, bus_resp_ready.
  - Internal capture registers cleared.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - stall = sram_en (combinational), so the pipeline freezes in the same cycle the request appears.
  - On sram_en, register:
    - addr as {sram_addr[ADDR_W-1:3],3'b000}
    - write = |sram_wea
    - wstrb = sram_wea
    - wdata = sram_dina
  - Then go to REQ.
- REQ:
  - bus_req_valid = 1; payload comes from the capture registers and is stable until handshake.
  - stall = 1.
  - On valid && ready, go to RESP.
  - bus_req_valid must not drop before the handshake.
- RESP:
  - bus_resp_ready = 1; stall = 1.
  - On bus_resp_valid, capture bus_resp_data into the sram_douta register (reads only; writes leave sram_douta unchanged).
  - Capture bus_resp_err into an error flag, then go to DONE.
- DONE (exactly one cycle):
  - stall = 0 and sram_douta is valid; the pipeline advances this cycle.
  - access_fault = error flag.
  - Next state is IDLE unconditionally. A new request held on sram_en is sampled in IDLE on the following cycle; the completed request is never reissued.
- Latency:
  - Minimum 4 cycles from sram_en to stall low (IDLE, REQ, RESP, DONE) with ready/resp_valid asserted immediately.
  - Each extra cycle of ready or resp_valid wait adds one cycle.
- Boundary conditions:
  - sram_addr[2:0] is ignored; the bus is always 8-byte aligned and lane selection stays in sram_wea/translator.
  - sram_en deasserted while stall is high (flush): the transaction still completes. sram_douta is updated, no access_fault is masked, and the return to IDLE is unchanged.
  - A bus_resp_valid seen outside RESP is ignored (bus_resp_ready is 0).
  - Reset asserted mid-transaction: immediate return to IDLE with bus_req_valid low. An outstanding bus response after reset release is ignored while in IDLE.
  - sram_douta holds its last read value across idle cycles and write transactions.

Optional Feature:
- Macro: SRAM64_BUS_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8..16-bit cycle counter runs in REQ and RESP and clears on entry to REQ.
  - When it reaches TIMEOUT_CYCLES, go to DONE with sram_douta = 0 (reads) and access_fault = 1.
  - bus_req_valid drops in that transition.
- Undefined: no counter; the bridge waits indefinitely in REQ/RESP.

Decomposition:
- Package sram64_bus_pkg holds:
  - bridge_state_e enum (IDLE, REQ, RESP, DONE)
  - typedef bus_req_t struct {addr, write, wstrb, wdata}
  - localparam BUS_ALIGN = 3
- One sub-module, sram64_bridge_wdt: watchdog counter with clear/enable/expired ports. Instantiated only under SRAM64_BUS_BRIDGE_TIMEOUT_EN.

Test Plan:
- Read, zero-wait bus:
  - Stimulus: sram_en=1, wea=0, addr=0x8000_0005; ready=1; resp_valid=1 the cycle after handshake with data 0x1122334455667788.
  - Required: bus_req_addr=0x8000_0000, write=0; stall high for 3 cycles then low 1 cycle; sram_douta=0x1122334455667788.
- Byte write:
  - Stimulus: wea=0x20, dina=0x0000_AB00_0000_0000, addr=0x100D; ready delayed 5 cycles.
  - Required: bus_req_valid held for 6 cycles with stable payload wstrb=0x20, addr=0x1008; sram_douta unchanged.
- Back-to-back:
  - Stimulus: read then write with sram_en held continuously.
  - Required: exactly two bus requests; one IDLE cycle between DONE and the second REQ.
- Bus error:
  - Stimulus: bus_resp_err=1 on a read.
  - Required: access_fault high exactly in the DONE cycle.
- Reset mid-RESP:
  - Stimulus: rst_n low in RESP.
  - Required: stall=0 and bus_req_valid=0 immediately; a stray resp_valid after release is ignored.
- Timeout (macro defined, TIMEOUT_CYCLES=10):
  - Stimulus: no bus_resp_valid.
  - Required: DONE after 10 cycles; access_fault=1; sram_douta=0.
